// File: rtl/hci_multiclass_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hci_multiclass_arbiter
// Purpose  : Per-bank fixed-priority arbiter for N_IN request classes with
//            starvation promotion and registered response routing.
// Revision : 1.0 - initial release
// ============================================================================
module hci_multiclass_arbiter #(
   parameter int unsigned N_IN    = 3,
   parameter int unsigned N_CH    = 16,
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned BW      = 8,
   parameter int unsigned IW      = 8,
   parameter int unsigned STALL_W = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clear_i,
   input  logic [STALL_W-1:0]          max_stall_i,
   input  logic [N_IN*N_CH-1:0]        in_req_i,
   output logic [N_IN*N_CH-1:0]        in_gnt_o,
   input  logic [N_IN*N_CH*AW-1:0]     in_add_i,
   input  logic [N_IN*N_CH-1:0]        in_wen_i,
   input  logic [N_IN*N_CH*DW-1:0]     in_data_i,
   input  logic [N_IN*N_CH*DW/BW-1:0]  in_be_i,
   input  logic [N_IN*N_CH*IW-1:0]     in_id_i,
   output logic [N_IN*N_CH*DW-1:0]     in_r_data_o,
   output logic [N_IN*N_CH-1:0]        in_r_valid_o,
   output logic [N_CH-1:0]             out_req_o,
   input  logic [N_CH-1:0]             out_gnt_i,
   output logic [N_CH*AW-1:0]          out_add_o,
   output logic [N_CH-1:0]             out_wen_o,
   output logic [N_CH*DW-1:0]          out_data_o,
   output logic [N_CH*DW/BW-1:0]       out_be_o,
   output logic [N_CH*IW-1:0]          out_id_o,
   input  logic [N_CH*DW-1:0]          out_r_data_i
);

   localparam int unsigned C_BEW   = DW / BW;
   localparam int unsigned C_IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [N_IN-1:0]    w_req;
      logic [N_IN-1:0]    w_gnt;
      logic [N_IN-1:0]    w_starved;
      logic [C_IDX_W-1:0] w_win;
      logic               w_any;
      logic [AW-1:0]      w_add;
      logic               w_wen;
      logic [DW-1:0]      w_data;
      logic [C_BEW-1:0]   w_be;
      logic [IW-1:0]      w_id;
      logic               r_pend;
      logic [C_IDX_W-1:0] r_sel;

      assign w_any        = |w_req;
      assign w_starved[0] = 1'b0;

      for (genvar k = 0; k < N_IN; k++) begin : g_cls
         assign w_req[k] = in_req_i[k*N_CH+c];
         assign w_gnt[k] = w_any && (w_win == C_IDX_W'(k)) && out_gnt_i[c];
         assign in_gnt_o[k*N_CH+c]     = w_gnt[k];
         assign in_r_valid_o[k*N_CH+c] = r_pend && (r_sel == C_IDX_W'(k));
         assign in_r_data_o[(k*N_CH+c)*DW +: DW] = out_r_data_i[c*DW +: DW];
      end

      // Class 0 is never starved, so only the lower-priority classes carry a counter.
      for (genvar k = 1; k < N_IN; k++) begin : g_cnt
         logic [STALL_W-1:0] r_cnt;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               r_cnt <= '0;
            end else if (clear_i) begin
               r_cnt <= '0;
            end else if (w_req[k] && !w_gnt[k]) begin
               if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            end else begin
               r_cnt <= '0;
            end
         end

         assign w_starved[k] = (max_stall_i != '0) && (r_cnt >= max_stall_i);
      end

      always_comb begin : p_select
         logic w_hit;
         w_hit = 1'b0;
         w_win = '0;
         for (int k = 0; k < N_IN; k++) begin
            if (!w_hit && w_req[k] && w_starved[k]) begin
               w_win = C_IDX_W'(k);
               w_hit = 1'b1;
            end
         end
         for (int k = 0; k < N_IN; k++) begin
            if (!w_hit && w_req[k]) begin
               w_win = C_IDX_W'(k);
               w_hit = 1'b1;
            end
         end
      end

      always_comb begin : p_mux
         w_add  = '0;
         w_wen  = 1'b0;
         w_data = '0;
         w_be   = '0;
         w_id   = '0;
         for (int k = 0; k < N_IN; k++) begin
            if (w_any && (w_win == C_IDX_W'(k))) begin
               w_add  = in_add_i[(k*N_CH+c)*AW +: AW];
               w_wen  = in_wen_i[k*N_CH+c];
               w_data = in_data_i[(k*N_CH+c)*DW +: DW];
               w_be   = in_be_i[(k*N_CH+c)*C_BEW +: C_BEW];
               w_id   = in_id_i[(k*N_CH+c)*IW +: IW];
            end
         end
      end

      // Response owner is latched at handshake; bank data returns one cycle later.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_pend <= 1'b0;
            r_sel  <= '0;
         end else if (clear_i) begin
            r_pend <= 1'b0;
            r_sel  <= '0;
         end else if (w_any && out_gnt_i[c]) begin
            r_pend <= 1'b1;
            r_sel  <= w_win;
         end else begin
            r_pend <= 1'b0;
         end
      end

      assign out_req_o[c]                = w_any;
      assign out_add_o[c*AW +: AW]       = w_add;
      assign out_wen_o[c]                = w_wen;
      assign out_data_o[c*DW +: DW]      = w_data;
      assign out_be_o[c*C_BEW +: C_BEW]  = w_be;
      assign out_id_o[c*IW +: IW]        = w_id;
   end

endmodule
`default_nettype wire

// File: tb/tb_hci_multiclass_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hci_multiclass_arbiter
// Purpose  : Directed and random stimulus against a queue/array reference
//            model, with a separate response monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hci_multiclass_arbiter;

   localparam int N_IN    = 3;
   localparam int N_CH    = 4;
   localparam int AW      = 16;
   localparam int DW      = 32;
   localparam int BW      = 8;
   localparam int IW      = 4;
   localparam int STALL_W = 3;
   localparam int BEW     = DW / BW;
   localparam int SAT     = (1 << STALL_W) - 1;
   localparam int NV      = N_IN * N_CH;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 clear_i = 1'b0;
   logic [STALL_W-1:0]   max_stall_i = '0;
   logic [NV-1:0]        in_req_i = '0;
   logic [NV-1:0]        in_gnt_o;
   logic [NV*AW-1:0]     in_add_i = '0;
   logic [NV-1:0]        in_wen_i = '0;
   logic [NV*DW-1:0]     in_data_i = '0;
   logic [NV*BEW-1:0]    in_be_i = '0;
   logic [NV*IW-1:0]     in_id_i = '0;
   logic [NV*DW-1:0]     in_r_data_o;
   logic [NV-1:0]        in_r_valid_o;
   logic [N_CH-1:0]      out_req_o;
   logic [N_CH-1:0]      out_gnt_i = '0;
   logic [N_CH*AW-1:0]   out_add_o;
   logic [N_CH-1:0]      out_wen_o;
   logic [N_CH*DW-1:0]   out_data_o;
   logic [N_CH*BEW-1:0]  out_be_o;
   logic [N_CH*IW-1:0]   out_id_o;
   logic [N_CH*DW-1:0]   out_r_data_i = '0;

   hci_multiclass_arbiter #(
      .N_IN(N_IN), .N_CH(N_CH), .AW(AW), .DW(DW), .BW(BW), .IW(IW), .STALL_W(STALL_W)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .max_stall_i(max_stall_i),
      .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i), .in_wen_i(in_wen_i),
      .in_data_i(in_data_i), .in_be_i(in_be_i), .in_id_i(in_id_i),
      .in_r_data_o(in_r_data_o), .in_r_valid_o(in_r_valid_o),
      .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_add_o(out_add_o),
      .out_wen_o(out_wen_o), .out_data_o(out_data_o), .out_be_o(out_be_o),
      .out_id_o(out_id_o), .out_r_data_i(out_r_data_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      int ch;
      int cls;
   } rsp_t;

   rsp_t exp_q[$];
   int   wait_cnt [N_CH][N_IN];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   wen_mode = 0;
   bit   force_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [NV-1:0] req_mask(input int ch, input logic [N_IN-1:0] cls);
      logic [NV-1:0] m;
      m = '0;
      for (int k = 0; k < N_IN; k++) if (cls[k]) m[k*N_CH+ch] = 1'b1;
      return m;
   endfunction

   // Starved requesters first, then plain requesters; lowest class index within each group.
   function automatic int model_winner(input int c, input logic [NV-1:0] req, input logic [STALL_W-1:0] mx);
      int best;
      best = -1;
      for (int k = 1; k < N_IN; k++)
         if (best < 0 && req[k*N_CH+c] && mx != 0 && wait_cnt[c][k] >= int'(mx)) best = k;
      for (int k = 0; k < N_IN; k++)
         if (best < 0 && req[k*N_CH+c]) best = k;
      return best;
   endfunction

   task automatic clear_model();
      for (int c = 0; c < N_CH; c++)
         for (int k = 0; k < N_IN; k++) wait_cnt[c][k] = 0;
   endtask

   task automatic run_cycle(input logic [NV-1:0] req, input logic [N_CH-1:0] gnt,
                            input logic clr, input logic [STALL_W-1:0] mx);
      logic [NV-1:0]       e_gnt;
      logic [N_CH-1:0]     e_req;
      logic [N_CH*AW-1:0]  e_add;
      logic [N_CH-1:0]     e_wen;
      logic [N_CH*DW-1:0]  e_data;
      logic [N_CH*BEW-1:0] e_be;
      logic [N_CH*IW-1:0]  e_id;
      int                  wins [N_CH];
      rsp_t                r;
      in_req_i = req; out_gnt_i = gnt; clear_i = clr; max_stall_i = mx;
      for (int i = 0; i < NV; i++) begin
         in_add_i[i*AW +: AW]    = AW'($urandom);
         in_data_i[i*DW +: DW]   = $urandom;
         in_be_i[i*BEW +: BEW]   = BEW'($urandom);
         in_id_i[i*IW +: IW]     = IW'($urandom);
         in_wen_i[i] = (wen_mode == 1) ? 1'b1 : (wen_mode == 2) ? 1'b0 : 1'($urandom);
      end
      for (int c = 0; c < N_CH; c++) out_r_data_i[c*DW +: DW] = $urandom;
      if (force_en) out_r_data_i[0 +: DW] = 32'hDEAD_BEEF;
      #2;
      e_gnt = '0; e_req = '0; e_add = '0; e_wen = '0; e_data = '0; e_be = '0; e_id = '0;
      for (int c = 0; c < N_CH; c++) begin
         wins[c] = model_winner(c, req, mx);
         if (wins[c] >= 0) begin
            e_req[c] = 1'b1;
            e_add[c*AW +: AW]    = in_add_i[(wins[c]*N_CH+c)*AW +: AW];
            e_wen[c]             = in_wen_i[wins[c]*N_CH+c];
            e_data[c*DW +: DW]   = in_data_i[(wins[c]*N_CH+c)*DW +: DW];
            e_be[c*BEW +: BEW]   = in_be_i[(wins[c]*N_CH+c)*BEW +: BEW];
            e_id[c*IW +: IW]     = in_id_i[(wins[c]*N_CH+c)*IW +: IW];
            if (gnt[c]) e_gnt[wins[c]*N_CH+c] = 1'b1;
         end
      end
      check("in_gnt", in_gnt_o, e_gnt);
      check("out_req", out_req_o, e_req);
      check("out_add", out_add_o, e_add);
      check("out_wen", out_wen_o, e_wen);
      check("out_data", out_data_o, e_data);
      check("out_be", out_be_o, e_be);
      check("out_id", out_id_o, e_id);
      if (clr) begin
         clear_model();
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            for (int k = 1; k < N_IN; k++) begin
               if (req[k*N_CH+c] && !(k == wins[c] && gnt[c]))
                  wait_cnt[c][k] = (wait_cnt[c][k] < SAT) ? wait_cnt[c][k] + 1 : SAT;
               else
                  wait_cnt[c][k] = 0;
            end
            if (wins[c] >= 0 && gnt[c]) begin
               r.due = cyc + 1; r.ch = c; r.cls = wins[c];
               exp_q.push_back(r);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin : p_monitor
      logic [NV-1:0]    ev;
      logic [NV*DW-1:0] ed;
      forever begin
         @(negedge clk);
         ev = '0;
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            if (exp_q[0].due == cyc) ev[exp_q[0].cls*N_CH + exp_q[0].ch] = 1'b1;
            void'(exp_q.pop_front());
         end
         for (int k = 0; k < N_IN; k++)
            for (int c = 0; c < N_CH; c++)
               ed[(k*N_CH+c)*DW +: DW] = out_r_data_i[c*DW +: DW];
         check("r_valid", in_r_valid_o, ev);
         check("r_data", in_r_data_o, ed);
      end
   end

   initial begin : p_stim
      logic [NV-1:0]   rq;
      logic [N_CH-1:0] gn;
      logic [STALL_W-1:0] mx;
      clear_model();
      #2;
      check("rst_gnt", in_gnt_o, '0);
      check("rst_rvalid", in_r_valid_o, '0);
      check("rst_out_req", out_req_o, '0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Pure fixed priority: class 0 always wins bank 3.
      repeat (12) run_cycle(req_mask(3, 3'b111), '1, 1'b0, 3'd0);
      run_cycle('0, '1, 1'b0, 3'd0);
      // Starvation promotion at threshold 4.
      repeat (24) run_cycle(req_mask(3, 3'b111), '1, 1'b0, 3'd4);
      run_cycle('0, '1, 1'b0, 3'd0);

      // Saturating stall counter: 10 stalled cycles against a 3-bit counter.
      repeat (10) run_cycle(req_mask(1, 3'b100), '0, 1'b0, 3'd3);
      repeat (2) run_cycle(req_mask(1, 3'b101), '1, 1'b0, 3'd3);
      run_cycle('0, '1, 1'b0, 3'd0);

      // Read by class 1 on bank 0 with known return data.
      wen_mode = 1;
      run_cycle(req_mask(0, 3'b010), 4'b0001, 1'b0, 3'd0);
      out_r_data_i[0 +: DW] = 32'hDEAD_BEEF;
      #1;
      check("rd_valid_c1b0", in_r_valid_o, 12'h010);
      check("rd_data_c1b0", in_r_data_o[(1*N_CH+0)*DW +: DW], 32'hDEAD_BEEF);
      force_en = 1'b1;
      run_cycle('0, '1, 1'b0, 3'd0);
      force_en = 1'b0;

      // Clear coincident with a granted write.
      wen_mode = 2;
      repeat (3) run_cycle(req_mask(1, 3'b011), '1, 1'b0, 3'd0);
      run_cycle(req_mask(1, 3'b011), '1, 1'b1, 3'd0);
      check("clr_no_rvalid", in_r_valid_o, '0);
      repeat (4) run_cycle(req_mask(1, 3'b011), '1, 1'b0, 3'd2);
      wen_mode = 0;

      // Asynchronous reset with a response in flight and counters loaded.
      repeat (6) run_cycle(req_mask(2, 3'b111), '1, 1'b0, 3'd0);
      in_req_i = '0; out_gnt_i = '0;
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_rvalid", in_r_valid_o, '0);
      exp_q.delete();
      clear_model();
      @(posedge clk); #1;
      check("in_rst_gnt", in_gnt_o, '0);
      check("in_rst_out_req", out_req_o, '0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      repeat (3) run_cycle(req_mask(2, 3'b111), '1, 1'b0, 3'd1);

      // Random traffic with occasional clears and threshold changes.
      mx = 3'd2;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NV; i++) rq[i] = ($urandom_range(0, 9) < 7);
         for (int c = 0; c < N_CH; c++) gn[c] = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0) mx = STALL_W'($urandom_range(0, 5));
         run_cycle(rq, gn, ($urandom_range(0, 39) == 0), mx);
      end

      repeat (2) run_cycle('0, '0, 1'b0, 3'd0);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
